// File: rtl/sha256_round_ctrl.sv
// Round sequencer for the CSA-based SHA-256 compression datapath.
// Optional abort input enabled by defining SHA256_CTRL_ABORT_EN.
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS = 64,
    parameter int MSG_WORDS  = 16,
    parameter int IDX_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             first_blk,
    input  logic             msg_valid,
`ifdef SHA256_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             msg_ready,
    output logic [IDX_W-1:0] round_idx,
    output logic             w_sel,
    output logic             rnd_en,
    output logic             init_hv,
    output logic             load_wv,
    output logic             hv_add,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] MSG_END = IDX_W'(MSG_WORDS);
    localparam logic [IDX_W-1:0] LAST_T  = IDX_W'(NUM_ROUNDS - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] t, t_n;
    logic             fb, fb_n;
    logic             msg_phase;
    logic             fire;
    logic             kill;

    // Shared decode: fire is Mealy on msg_valid during message rounds.
    always_comb begin
        msg_phase = (state == ROUND) && (t < MSG_END);
        fire      = (state == ROUND) && (msg_phase ? msg_valid : 1'b1);
        kill      = 1'b0;
`ifdef SHA256_CTRL_ABORT_EN
        kill      = abort && ((state == INIT) || (state == ROUND) || (state == FINAL));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            t     <= '0;
            fb    <= 1'b0;
        end else begin
            state <= state_n;
            t     <= t_n;
            fb    <= fb_n;
        end
    end

    always_comb begin
        state_n = state;
        t_n     = t;
        fb_n    = fb;
        unique case (state)
            IDLE: begin
                if (start) begin
                    fb_n    = first_blk;
                    t_n     = '0;
                    state_n = INIT;
                end
            end
            INIT:  state_n = ROUND;
            ROUND: begin
                if (fire) begin
                    if (t == LAST_T) begin
                        t_n     = '0;
                        state_n = FINAL;
                    end else begin
                        t_n = t + IDX_W'(1);
                    end
                end
            end
            FINAL: state_n = DONE;
            DONE:  state_n = IDLE;
            default: begin
                state_n = IDLE;
                t_n     = '0;
            end
        endcase
        if (kill) begin
            state_n = IDLE;
            t_n     = '0;
        end
    end

    always_comb begin
        msg_ready = msg_phase;
        round_idx = t;
        w_sel     = (state == ROUND) && !msg_phase;
        rnd_en    = fire;
        init_hv   = (state == INIT) && fb;
        load_wv   = (state == INIT);
        hv_add    = (state == FINAL);
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: per-cycle output checks plus a
// scoreboard of expected round indices for every accepted message word.
module tb_sha256_round_ctrl;

    localparam int NR = 64;
    localparam int MW = 16;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          first_blk = 1'b0;
    logic          msg_valid = 1'b0;
`ifdef SHA256_CTRL_ABORT_EN
    logic          abort = 1'b0;
`endif
    logic          msg_ready;
    logic [IW-1:0] round_idx;
    logic          w_sel, rnd_en, init_hv, load_wv, hv_add, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int words  = 0;
    int exp_idx[$];

    sha256_round_ctrl #(.NUM_ROUNDS(NR), .MSG_WORDS(MW), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_blk (first_blk),
        .msg_valid (msg_valid),
`ifdef SHA256_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .msg_ready (msg_ready),
        .round_idx (round_idx),
        .w_sel     (w_sel),
        .rnd_en    (rnd_en),
        .init_hv   (init_hv),
        .load_wv   (load_wv),
        .hv_add    (hv_add),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Every handshake must match the next word the stimulus queued.
    always @(negedge clk) begin
        int want;
        if (!rst && msg_valid && msg_ready) begin
            words++;
            want = (exp_idx.size() > 0) ? exp_idx.pop_front() : -1;
            chk("word_idx", 32'(round_idx), 32'(want));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic outs_zero(input string tag);
        chk(tag, 32'({msg_ready, round_idx, w_sel, rnd_en, init_hv, load_wv, hv_add, busy, done}), 32'd0);
    endtask

    task automatic run_block(input logic fb, input int bp_at, input int rst_at,
                             input int abort_at, input bit start_in_done);
        int c0;
        int extra;
        int reps;
        bit stall;
        extra     = (bp_at >= 0) ? 3 : 0;
        words     = 0;
        start     = 1'b1;
        first_blk = fb;
        c0        = cyc;
        step();
        start     = 1'b0;
        first_blk = ~fb;
        #1;
        chk("init", 32'({busy, load_wv, init_hv, rnd_en, msg_ready, hv_add, done, round_idx}),
            32'({1'b1, 1'b1, fb, 4'b0000, 6'd0}));
        chk("init_cycle", 32'(cyc - c0), 32'd1);
        for (int k = 0; k < NR; k++) begin
            reps = (k == bp_at) ? 4 : 1;
            for (int r = 0; r < reps; r++) begin
                step();
                stall     = (r < reps - 1);
                msg_valid = !stall;
                if (k < MW && !stall) exp_idx.push_back(k);
                start = (k == 30 && r == 0);
`ifdef SHA256_CTRL_ABORT_EN
                abort = (k == abort_at);
`endif
                if (k == rst_at) begin
                    rst = 1'b1;
                    msg_valid = 1'b0;
                    #1;
                    outs_zero("reset_mid");
                    step();
                    rst = 1'b0;
                    #1;
                    outs_zero("reset_release");
                    return;
                end
                #1;
                chk("round", 32'({round_idx, rnd_en, msg_ready, w_sel, busy}),
                    32'({IW'(k), !stall, k < MW, k >= MW, 1'b1}));
                if (k == abort_at) begin
                    step();
`ifdef SHA256_CTRL_ABORT_EN
                    abort = 1'b0;
`endif
                    msg_valid = 1'b0;
                    #1;
                    outs_zero("abort_idle");
                    step();
                    #1;
                    outs_zero("abort_no_done");
                    chk("abort_words", 32'(words), 32'(MW));
                    return;
                end
            end
        end
        step();
        msg_valid = 1'b0;
        start     = 1'b0;
        #1;
        chk("final", 32'({hv_add, done, busy, round_idx, rnd_en, msg_ready, w_sel}),
            32'({1'b1, 1'b0, 1'b1, 6'd0, 3'b000}));
        chk("final_cycle", 32'(cyc - c0), 32'(NR + 2 + extra));
        step();
        start = start_in_done;
        #1;
        chk("done", 32'({done, hv_add, busy, round_idx}), 32'({3'b101, 6'd0}));
        chk("done_cycle", 32'(cyc - c0), 32'(NR + 3 + extra));
        step();
        start = 1'b0;
        #1;
        chk("idle_after", 32'({done, busy}), 32'd0);
        if (start_in_done) begin
            step();
            #1;
            chk("done_start_dropped", 32'({busy, load_wv}), 32'd0);
        end
        chk("word_count", 32'(words), 32'(MW));
        chk("queue_drained", 32'(exp_idx.size()), 32'd0);
    endtask

    initial begin
        step();
        step();
        outs_zero("reset");
        rst = 1'b0;
        step();
        msg_valid = 1'b1;
        #1;
        chk("idle_ignores_valid", 32'({msg_ready, rnd_en, busy}), 32'd0);
        msg_valid = 1'b0;
        step();
        outs_zero("idle");

        run_block(1'b1, -1, -1, -1, 1'b0);
        run_block(1'b1, 5, -1, -1, 1'b0);
        run_block(1'b0, -1, -1, -1, 1'b1);
        run_block(1'b1, -1, 20, -1, 1'b0);
        run_block(1'b0, -1, -1, -1, 1'b0);
`ifdef SHA256_CTRL_ABORT_EN
        run_block(1'b1, -1, -1, 40, 1'b0);
        run_block(1'b1, -1, -1, -1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencer for the SHA-256 compression datapath built from carry-save adders. It accepts a start request and accepts 16 message words through a valid/ready handshake. It then steps the shared round datapath through all compression rounds, drives the final hash-accumulate step, and reports completion. It sits between the block-level host interface and the CSA-based round/message-schedule datapath, which it controls only through strobes and a round index.

## Interface
Parameters:
- NUM_ROUNDS, 64, compression rounds per block; must exceed MSG_WORDS.
- MSG_WORDS, 16, rounds that consume an external message word; later rounds use schedule expansion.
- IDX_W, 6, width of round_idx; must satisfy 2^IDX_W >= NUM_ROUNDS.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to hash one block; sampled only in IDLE.
- first_blk  in  1  sampled with start; 1 = load initial hash constants before the block.
- msg_valid  in  1  message word present on datapath input.
- msg_ready  out  1  controller accepts a message word this cycle.
- round_idx  out  IDX_W  current round t, selects K[t] and the W source.
- w_sel  out  1  0 = W from message input, 1 = W from schedule expansion.
- rnd_en  out  1  datapath executes one round and registers its result this cycle.
- init_hv  out  1  load H0..H7 initial constants into the hash registers.
- load_wv  out  1  copy the hash registers into working variables a..h.
- hv_add  out  1  hash registers += working variables (final CSA accumulate).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- State register with states IDLE, INIT, ROUND, FINAL, DONE. Round counter t is IDX_W bits wide. fb is a flag that holds first_blk.
- IDLE: all strobes low. When start=1: fb<=first_blk, t<=0, go to INIT. start is ignored in every other state.
- INIT, one cycle: load_wv=1, and init_hv=fb. If init_hv and load_wv are both high, the datapath loads the constants into both the hash and working registers. Then go to ROUND.
- ROUND, t < MSG_WORDS:
  - msg_ready=1, w_sel=0, rnd_en=msg_valid.
  - t increments only on cycles where rnd_en=1. When msg_valid=0, the state is held with no round executed.
- ROUND, t >= MSG_WORDS: msg_ready=0, w_sel=1, rnd_en=1 every cycle.
- When rnd_en=1 and t=NUM_ROUNDS-1: t<=0 and go to FINAL. The counter never wraps past NUM_ROUNDS-1.
- FINAL, one cycle: hv_add=1, then go to DONE.
- DONE, one cycle: done=1, then go to IDLE. A start seen in the DONE cycle is dropped; start is accepted only from the cycle after DONE, in IDLE.
- round_idx = t in every state; it is 0 outside ROUND.
- msg_ready is low in every state except ROUND with t < MSG_WORDS. A msg_valid arriving outside that window is ignored and is not counted.

## Timing
- Reset (asynchronous assert, release at a clk edge): state=IDLE, t=0, fb=0. All outputs are 0: msg_ready, round_idx, w_sel, rnd_en, init_hv, load_wv, hv_add, busy, done.
- state, t and fb are registered. Outputs are decoded combinationally from the registers. rnd_en in message rounds is additionally combinational from msg_valid (the handshake path is Mealy).
- With start in cycle 0 and msg_valid held high:
  - INIT in cycle 1.
  - ROUND in cycles 2..NUM_ROUNDS+1.
  - FINAL in cycle NUM_ROUNDS+2.
  - done in cycle NUM_ROUNDS+3 (67 for defaults).
- Each cycle of msg_valid=0 during a message round adds exactly one cycle of latency.
- A word transfers when msg_valid and msg_ready are both high at a clk edge. At most one word transfers per cycle.
- Reset asserted mid-block immediately forces the reset values. No done pulse is issued, and partial datapath state is not the controller's concern.

## Configuration
- SHA256_CTRL_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 in INIT, ROUND or FINAL: the next state is IDLE with t=0, and no hv_add or done is issued.
  - abort takes priority over every other transition.
  - abort has no effect in IDLE or DONE.
- Not defined: no abort port exists, and a started block always runs to DONE.

## Test plan
- Reset: assert rst mid-ROUND at t=20 -> all outputs 0 immediately, busy=0; a later start runs a full block normally.
- Basic: start=1 with first_blk=1 and msg_valid always high -> init_hv=load_wv=1 in cycle 1; w_sel flips to 1 when round_idx=16; hv_add in cycle 66; done pulse in cycle 67, exactly one cycle wide.
- Back-pressure: drop msg_valid for 3 cycles at t=5 -> round_idx holds at 5 with rnd_en=0; done is delayed to cycle 70; exactly 16 words are accepted.
- Chained block: start with first_blk=0 -> init_hv stays 0 in INIT and load_wv=1; start asserted during ROUND is ignored; start in the DONE cycle is dropped.
- Boundary: msg_valid held high while t>=16 -> msg_ready=0 and no extra word is counted; round_idx peaks at 63 and never reaches 64.
- SHA256_CTRL_ABORT_EN: abort at t=40 -> IDLE next cycle, no hv_add, no done; a following start completes normally.
